// File: rtl/add_sub_pkg.sv
// Shared types and elaboration helpers for the pipelined add/sub datapath.
package add_sub_pkg;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

  function automatic int unsigned stages_of(input int unsigned width, input int unsigned seg);
    return (seg == 0 || width < seg) ? 1 : width / seg;
  endfunction

  function automatic bit seg_fits(input int unsigned width, input int unsigned seg);
    return (seg != 0) && (width >= seg) && (width % seg == 0);
  endfunction

  // Saturation limits, returned wide and narrowed by the user to its WIDTH.
  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'(1) << (width - 1)) - 64'(1);
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/seg_adder.sv
// Combinational SEG-bit ripple adder; also exposes the carry into its MSB for overflow detection.
module seg_adder #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           c_msb_in
);

  logic [SEG:0] cy;

  always_comb begin
    cy    = '0;
    s     = '0;
    cy[0] = cin;
    for (int i = 0; i < SEG; i++) begin
      s[i]    = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end
  end

  assign cout     = cy[SEG];
  assign c_msb_in = cy[SEG-1];

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined two's-complement add/sub: one SEG-bit carry segment per stage, valid/ready
// handshake with a single pipe-wide advance enable, optional signed saturation.
module add_sub_pipe
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             v,
  output logic             n,
  output logic             z
);

  localparam int unsigned STAGES = stages_of(WIDTH, SEG);
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  if (!seg_fits(WIDTH, SEG)) begin : g_param_check
    $error("add_sub_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  logic              en;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] vin;

  // Stage registers; operands travel whole, unread low slices are dead and trimmed away.
  logic [WIDTH-1:0] x_q  [STAGES];
  logic [WIDTH-1:0] y_q  [STAGES];
  logic [WIDTH-1:0] s_q  [STAGES];
  logic             c_q  [STAGES];
  logic             sb_q [STAGES];
  logic             st_q [STAGES];

  logic [WIDTH-1:0] xi   [STAGES];
  logic [WIDTH-1:0] yi   [STAGES];
  logic [WIDTH-1:0] si   [STAGES];
  logic [WIDTH-1:0] s_nx [STAGES];
  logic             ci   [STAGES];
  logic             sbi  [STAGES];
  logic             sti  [STAGES];

  logic [SEG-1:0] a_seg [STAGES];
  logic [SEG-1:0] b_seg [STAGES];
  logic [SEG-1:0] s_seg [STAGES];
  logic           co    [STAGES];
  logic           cm    [STAGES];

  logic [WIDTH-1:0] res;
  logic             ovf;
  flags_t           flg_nx;
  logic [WIDTH-1:0] sum_q;
  flags_t           flg_q;

  assign en       = ~vld[STAGES-1] | out_ready;
  assign in_ready = en;
  // Valid entering each stage: port valid for stage 0, previous stage's valid otherwise.
  assign vin      = STAGES'({vld, in_valid});

  // Operand routing into each stage's segment adder.
  always_comb begin
    xi[0]  = x;
    yi[0]  = y;
    si[0]  = '0;
    ci[0]  = sub;
    sbi[0] = sub;
    sti[0] = sat;
    for (int k = 1; k < STAGES; k++) begin
      xi[k]  = x_q[k-1];
      yi[k]  = y_q[k-1];
      si[k]  = s_q[k-1];
      ci[k]  = c_q[k-1];
      sbi[k] = sb_q[k-1];
      sti[k] = st_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      a_seg[k] = xi[k][k*SEG +: SEG];
      b_seg[k] = yi[k][k*SEG +: SEG] ^ {SEG{sbi[k]}};
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    seg_adder #(.SEG(SEG)) u_seg (
      .a        (a_seg[k]),
      .b        (b_seg[k]),
      .cin      (ci[k]),
      .s        (s_seg[k]),
      .cout     (co[k]),
      .c_msb_in (cm[k])
    );
  end

  // Merge each stage's new slice into the partial sum travelling with the beat.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_nx[k]                 = si[k];
      s_nx[k][k*SEG +: SEG]   = s_seg[k];
    end
  end

  // Final stage: overflow, saturation toward the sign of x (the true result's sign on overflow), flags.
  always_comb begin
    ovf    = cm[STAGES-1] ^ co[STAGES-1];
    res    = s_nx[STAGES-1];
    flg_nx = '0;
    if (sti[STAGES-1] && ovf) begin
      res = xi[STAGES-1][WIDTH-1] ? SMIN : SMAX;
    end
    flg_nx.c = co[STAGES-1];
    flg_nx.v = ovf;
    flg_nx.n = res[WIDTH-1];
    flg_nx.z = (res == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld   <= '0;
      sum_q <= '0;
      flg_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k]  <= '0;
        y_q[k]  <= '0;
        s_q[k]  <= '0;
        c_q[k]  <= 1'b0;
        sb_q[k] <= 1'b0;
        st_q[k] <= 1'b0;
      end
    end else if (en) begin
      vld <= vin;
      for (int k = 0; k < STAGES; k++) begin
        if (vin[k]) begin
          x_q[k]  <= xi[k];
          y_q[k]  <= yi[k];
          s_q[k]  <= s_nx[k];
          c_q[k]  <= co[k];
          sb_q[k] <= sbi[k];
          st_q[k] <= sti[k];
        end
      end
      if (vin[STAGES-1]) begin
        sum_q <= res;
        flg_q <= flg_nx;
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign sum       = sum_q;
  assign cout      = flg_q.c;
  assign v         = flg_q.v;
  assign n         = flg_q.n;
  assign z         = flg_q.z;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Self-checking bench for add_sub_pipe (WIDTH=16, SEG=4): directed vectors, backpressure,
// mid-flight reset and randomized traffic against an integer-arithmetic reference.
module tb_add_sub_pipe;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SEG   = 4;
  localparam int          LAT   = 4;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, sub, sat, out_valid, out_ready, cout, v, n, z;
  logic [15:0] x, y, sum;

  int checks   = 0;
  int failures = 0;

  logic [19:0] sbq[$];
  int          sent, rcvd;
  logic        hold_vld, accepted;
  logic [19:0] hold_val;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic        st;
    logic [15:0] sum;
    logic [3:0]  f;
  } vec_t;

  vec_t tbl [11];

  always #5 clk = ~clk;

  add_sub_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .v         (v),
    .n         (n),
    .z         (z)
  );

  // Reference: true signed result decides overflow and clamp; unsigned 17-bit sum gives carry.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic s, input logic st);
    int          ia, ib, r;
    logic [16:0] u;
    logic [15:0] rs;
    logic        vv;
    ia = int'($signed(a));
    ib = int'($signed(b));
    r  = s ? ia - ib : ia + ib;
    u  = s ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
    vv = (r > 32767) || (r < -32768);
    rs = u[15:0];
    if (st && vv) rs = (r > 0) ? 16'h7FFF : 16'h8000;
    return {rs, u[16], vv, rs[15], (rs == 16'h0000)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One cycle of scoreboarded traffic; samples at the falling edge, returns at posedge+1.
  task automatic step();
    @(negedge clk);
    chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
    if (hold_vld) begin
      chk("held_valid", 32'(out_valid), 32'd1);
      chk("held_stable", 32'({sum, cout, v, n, z}), 32'(hold_val));
    end
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_out actual=%0h expected=no_beat", {sum, cout, v, n, z});
      end else begin
        chk("result", 32'({sum, cout, v, n, z}), 32'(sbq.pop_front()));
        rcvd++;
      end
    end
    hold_vld = out_valid && !out_ready;
    hold_val = {sum, cout, v, n, z};
    accepted = in_valid && in_ready;
    if (accepted) begin
      sbq.push_back(model(x, y, sub, sat));
      sent++;
    end
    @(posedge clk);
    #1;
  endtask

  // Single isolated beat on an empty pipe; operands are scrambled right after transfer.
  task automatic one_beat(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic st, output int lat, output logic [19:0] got);
    in_valid  = 1'b1;
    x         = a;
    y         = b;
    sub       = s;
    sat       = st;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x        = 16'hDEAD;
    y        = 16'hBEEF;
    sub      = ~s;
    sat      = ~st;
    lat      = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = {sum, cout, v, n, z};
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    logic [19:0] got;
    int          base, s0, r0, idx;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; sub = 1'b0; sat = 1'b0;
    hold_vld = 1'b0; accepted = 1'b0; sent = 0; rcvd = 0;

    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_flags", 32'({cout, v, n, z}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // a, b, sub, sat -> sum, {c,v,n,z}
    tbl[0]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 4'b0110};
    tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 4'b0100};
    tbl[2]  = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 4'b0010};
    tbl[3]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 4'b1110};
    tbl[4]  = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 4'b1001};
    tbl[5]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'b1001};
    tbl[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 4'b1110};
    tbl[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 4'b1101};
    tbl[8]  = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h7FFF, 4'b0100};
    tbl[9]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 4'b1001};
    tbl[10] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 4'b0000};

    for (int i = 0; i < 11; i++) begin
      one_beat(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].st, lat, got);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      chk($sformatf("vec%0d_sum", i), 32'(got[19:4]), 32'(tbl[i].sum));
      chk($sformatf("vec%0d_flags", i), 32'(got[3:0]), 32'(tbl[i].f));
    end

    // Eight back-to-back beats with the consumer stalled in cycles 3..5.
    base = rcvd;
    idx  = 0;
    for (int c = 0; c < 30; c++) begin
      in_valid  = (idx < 8);
      x         = 16'(idx * 4369);
      y         = 16'(idx * 7 + 1);
      sub       = (idx % 2 == 1);
      sat       = (idx > 4);
      out_ready = !(c >= 3 && c <= 5);
      if (c == 4 || c == 5) begin
        #1;
        chk($sformatf("bp_stall_in_ready_c%0d", c), 32'(in_ready), 32'd0);
        chk($sformatf("bp_stall_out_valid_c%0d", c), 32'(out_valid), 32'd1);
      end
      step();
      if (accepted) idx++;
    end
    chk("bp_delivered", 32'(rcvd - base), 32'd8);
    chk("bp_queue_empty", 32'(sbq.size()), 32'd0);

    // Reset with three beats in flight and the head beat waiting at the output.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x = 16'(16'h0100 + i);
      y = 16'h0011;
      sub = 1'b0;
      sat = 1'b0;
      step();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 8 && !out_valid; c++) step();
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid", 32'(out_valid), 32'd0);
    chk("rst_async_sum", 32'(sum), 32'd0);
    sbq.delete();
    hold_vld = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("post_rst_no_stale_c%0d", c), 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    one_beat(16'h4000, 16'h4000, 1'b0, 1'b1, lat, got);
    chk("post_rst_latency", 32'(lat), 32'(LAT));
    chk("post_rst_result", 32'(got), 32'(model(16'h4000, 16'h4000, 1'b0, 1'b1)));

    // Randomized traffic with random backpressure and biased corner operands.
    s0 = sent;
    r0 = rcvd;
    accepted = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (accepted || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 4))
          0:       x = 16'h7FFF;
          1:       x = 16'h8000;
          2:       x = 16'hFFFF;
          default: x = 16'($urandom);
        endcase
        case ($urandom_range(0, 4))
          0:       y = 16'h0001;
          1:       y = 16'h8000;
          2:       y = 16'h7FFF;
          default: y = 16'($urandom);
        endcase
        sub = 1'($urandom);
        sat = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && sbq.size() != 0; c++) step();
    chk("rand_drain_empty", 32'(sbq.size()), 32'd0);
    chk("rand_count", 32'(rcvd - r0), 32'(sent - s0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
